servo_adc_pid_trunc: RTL



---
 rtl/servo_adc_pid_trunc_pkg.sv | 35 +++
 rtl/servo_adc_pid_trunc_if.sv | 28 ++
 rtl/servo_adc_pid_trunc_adc_rx.sv | 77 +++++++
 rtl/servo_adc_pid_trunc.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/servo_adc_pid_trunc_pkg.sv
// Shared types and helpers for the servo ADC/PID front end.
//   state_t     : sequencer states (IDLE, CONV, CALC1..CALC3)
//   frame_bits  : serial frame length = leading zeros + sample bits
//   clip_s      : clamp a signed value into a w-bit signed range
// Datapath intermediates are evaluated in SAT_W bits, so sums/products of the
// chosen widths must fit in 64 bits.
package servo_adc_pid_trunc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_CALC1,
    S_CALC2,
    S_CALC3
  } state_t;

  localparam int SAT_W = 64;

  function automatic int frame_bits(input int lead_bits, input int adc_w);
    return lead_bits + adc_w;
  endfunction

  function automatic logic signed [SAT_W-1:0] clip_s(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/servo_adc_pid_trunc_if.sv
// Pin/result bundle of the servo front end.
//   DataIn, SClk, CS_n        : ADC serial pins
//   Sample, SampleValid       : last received sample + update strobe
//   CtrlOut, CtrlValid, SatFlag : signed command, update strobe, clip flag
// master = the servo block, slave = ADC/PWM side.
interface servo_adc_pid_trunc_if #(
  parameter int ADC_W = 12,
  parameter int OUT_W = 8
);
  logic                    DataIn;
  logic                    SClk;
  logic                    CS_n;
  logic [ADC_W-1:0]        Sample;
  logic                    SampleValid;
  logic signed [OUT_W-1:0] CtrlOut;
  logic                    CtrlValid;
  logic                    SatFlag;

  modport master (
    input  DataIn,
    output SClk, CS_n, Sample, SampleValid, CtrlOut, CtrlValid, SatFlag
  );

  modport slave (
    output DataIn,
    input  SClk, CS_n, Sample, SampleValid, CtrlOut, CtrlValid, SatFlag
  );
endinterface

// File: rtl/servo_adc_pid_trunc_adc_rx.sv
// Serial ADC receiver: drives CS_n/SClk and deserialises one frame.
//   clk, rst  : clock, async active-high reset
//   start     : begin a frame (ignored while busy)
//   data_in   : ADC serial data, sampled on SClk rising edges, MSB first
//   sclk,cs_n : ADC clock (idles high) and chip select
//   sample    : low ADC_W bits of the last frame (leading zeros drop out)
//   done      : one-cycle strobe, cycle after sample loads
//   last      : combinational, high in the cycle ending on the final rising edge
module adc_serial_rx
  import servo_adc_pid_trunc_pkg::*;
#(
  parameter int ADC_W     = 12,
  parameter int LEAD_BITS = 4,
  parameter int CLK_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_in,
  output logic             sclk,
  output logic             cs_n,
  output logic [ADC_W-1:0] sample,
  output logic             done,
  output logic             last
);
  localparam int FB = frame_bits(LEAD_BITS, ADC_W);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FB);

  logic             busy;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [ADC_W-1:0] shreg;
  logic             tick, rise;

  // tick = end of a SClk half-period; toggling a low SClk is a rising edge
  assign tick = busy && (div_cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign last = rise && (bit_cnt == BW'(FB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sample  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy    <= 1'b1;
        cs_n    <= 1'b0;
        sclk    <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          sclk <= !sclk;
          if (rise) begin
            shreg   <= {shreg[ADC_W-2:0], data_in};
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              busy   <= 1'b0;
              cs_n   <= 1'b1;
              sample <= {shreg[ADC_W-2:0], data_in};
              done   <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/servo_adc_pid_trunc.sv
// Servo front end: periodic ADC read, fixed-point PID, truncate + clip.
//   Clk, Rest          : clock, async active-high reset
//   En                 : enable periodic conversions
//   Setpoint           : target position (unsigned)
//   Kp, Ki, Kd         : signed Q(COEF_W-FRAC).FRAC gains
//   ClrInt             : clear integrator and previous error
//   bus (master)       : ADC pins, Sample/SampleValid, CtrlOut/CtrlValid/SatFlag
// Sequence: IDLE -> CONV -> CALC1 (error) -> CALC2 (products) -> CALC3 (sum,
// shift, clip); CtrlValid follows SampleValid by exactly 3 cycles.
module servo_adc_pid_trunc
  import servo_adc_pid_trunc_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int LEAD_BITS  = 4,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 2000,
  parameter int COEF_W     = 16,
  parameter int FRAC       = 8,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 8
) (
  input  logic                     Clk,
  input  logic                     Rest,
  input  logic                     En,
  input  logic [ADC_W-1:0]         Setpoint,
  input  logic signed [COEF_W-1:0] Kp,
  input  logic signed [COEF_W-1:0] Ki,
  input  logic signed [COEF_W-1:0] Kd,
  input  logic                     ClrInt,
  servo_adc_pid_trunc_if.master    bus
);
  localparam int EW    = ADC_W + 1;
  localparam int DW    = ADC_W + 2;
  localparam int PW    = COEF_W + EW;
  localparam int IW    = COEF_W + ACC_W;
  localparam int DPW   = COEF_W + DW;
  localparam int MW0   = (PW > IW) ? PW : IW;
  localparam int MW    = (MW0 > DPW) ? MW0 : DPW;
  localparam int SW    = MW + 2;  // three-term sum cannot overflow
  localparam int CNT_W = $clog2(SAMPLE_DIV);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_cnt;
  logic             start, rx_last, rx_done, sclk, cs_n;
  logic [ADC_W-1:0] sample;

  logic signed [EW-1:0]    e_q, e_prev;
  logic signed [DW-1:0]    d_q;
  logic signed [ACC_W-1:0] acc, a_next_q;
  logic signed [PW-1:0]    p_q;
  logic signed [IW-1:0]    i_q;
  logic signed [DPW-1:0]   dt_q;
  logic signed [OUT_W-1:0] ctrl;
  logic                    ctrl_valid, sat;

  logic signed [EW-1:0]    e_c;
  logic signed [DW-1:0]    d_c;
  logic signed [ACC_W-1:0] a_next_c;
  logic signed [SW-1:0]    s_c, y_c;
  logic signed [SAT_W-1:0] y_clip;
  logic                    sat_c, hold_c, e_pos;

  // Sample-rate counter; parked at 0 while disabled so En=1 starts at once
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest)                                    per_cnt <= '0;
    else if (!En)                                per_cnt <= '0;
    else if (per_cnt == CNT_W'(SAMPLE_DIV - 1))  per_cnt <= '0;
    else                                         per_cnt <= per_cnt + 1'b1;
  end

  assign start = En && (per_cnt == '0) && (state_q == S_IDLE);

  adc_serial_rx #(
    .ADC_W    (ADC_W),
    .LEAD_BITS(LEAD_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_rx (
    .clk    (Clk),
    .rst    (Rest),
    .start  (start),
    .data_in(bus.DataIn),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .sample (sample),
    .done   (rx_done),
    .last   (rx_last)
  );

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)   state_d = S_CONV;
      S_CONV:  if (rx_last) state_d = S_CALC1;  // CALC1 lines up with SampleValid
      S_CALC1: state_d = S_CALC2;
      S_CALC2: state_d = S_CALC3;
      S_CALC3: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    e_c      = $signed({1'b0, Setpoint}) - $signed({1'b0, sample});
    d_c      = DW'(e_c) - DW'(e_prev);
    a_next_c = ACC_W'(clip_s(SAT_W'(acc) + SAT_W'(e_q), ACC_W));
    s_c      = SW'(p_q) + SW'(i_q) + SW'(dt_q);
    y_c      = s_c >>> FRAC;
    y_clip   = clip_s(SAT_W'(y_c), OUT_W);
    sat_c    = (y_clip != SAT_W'(y_c));
    e_pos    = !e_q[EW-1] && (e_q != '0);
    // Freeze the integrator only when it is pushing further into the clip
    hold_c   = sat_c && ((!y_c[SW-1] && e_pos) || (y_c[SW-1] && e_q[EW-1]));
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      e_q        <= '0;
      d_q        <= '0;
      e_prev     <= '0;
      acc        <= '0;
      a_next_q   <= '0;
      p_q        <= '0;
      i_q        <= '0;
      dt_q       <= '0;
      ctrl       <= '0;
      sat        <= 1'b0;
      ctrl_valid <= 1'b0;
    end else begin
      ctrl_valid <= 1'b0;
      if (state_q == S_CALC1) begin
        e_q <= e_c;
        d_q <= d_c;
      end
      if (state_q == S_CALC2) begin
        a_next_q <= a_next_c;
        p_q      <= PW'(Kp) * PW'(e_q);
        i_q      <= IW'(Ki) * IW'(a_next_c);
        dt_q     <= DPW'(Kd) * DPW'(d_q);
      end
      if (state_q == S_CALC3) begin
        ctrl       <= OUT_W'(y_clip);
        sat        <= sat_c;
        ctrl_valid <= 1'b1;
      end
      // Clear takes priority over the CALC3 writeback
      if (ClrInt) begin
        acc    <= '0;
        e_prev <= '0;
      end else if (state_q == S_CALC3) begin
        e_prev <= e_q;
        if (!hold_c) acc <= a_next_q;
      end
    end
  end

  assign bus.SClk        = sclk;
  assign bus.CS_n        = cs_n;
  assign bus.Sample      = sample;
  assign bus.SampleValid = rx_done;
  assign bus.CtrlOut     = ctrl;
  assign bus.CtrlValid   = ctrl_valid;
  assign bus.SatFlag     = sat;
endmodule
